// File: rtl/vx_fp_rsp_arbiter.sv
// Round-robin merge of FP core responses into one port via a 2-entry FIFO; 1-cycle latency.
// Backpressure: ready_in drops only when the FIFO is full, independent of ready_out; head holds while stalled.
module vx_fp_rsp_arbiter #(
  parameter int NUM_REQS = 5,
  parameter int LANES    = 1,
  parameter int TAGW     = 1,
  localparam int SELW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQS-1:0]         valid_in,
  output logic [NUM_REQS-1:0]         ready_in,
  input  logic [NUM_REQS*TAGW-1:0]    tag_in,
  input  logic [NUM_REQS*LANES*32-1:0] result_in,
  input  logic [NUM_REQS-1:0]         has_fflags_in,
  input  logic [NUM_REQS*LANES*5-1:0] fflags_in,
  output logic                        valid_out,
  input  logic                        ready_out,
  output logic [TAGW-1:0]             tag_out,
  output logic [LANES*32-1:0]         result_out,
  output logic                        has_fflags_out,
  output logic [4:0]                  fflags_out,
  output logic [SELW-1:0]             sel_out
);

  typedef struct packed {
    logic [SELW-1:0]     sel;
    logic                has_ff;
    logic [4:0]          ff;
    logic [TAGW-1:0]     tag;
    logic [LANES*32-1:0] res;
  } entry_t;

  entry_t              r_head;
  entry_t              r_tail;
  entry_t              w_new;
  logic [1:0]          r_count;
  logic [SELW-1:0]     r_rr_ptr;
  logic [SELW-1:0]     w_gnt_idx;
  logic [SELW-1:0]     w_rr_next;
  logic                w_gnt_vld;
  logic [NUM_REQS-1:0] w_gnt;
  logic                w_space;
  logic                w_push;
  logic                w_pop;

  // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQS.
  always_comb begin
    int idx;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (!w_gnt_vld && valid_in[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = SELW'(idx);
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    if (w_gnt_vld) w_gnt = NUM_REQS'(1) << w_gnt_idx;
  end

  assign w_space   = (r_count < 2'd2);
  assign ready_in  = w_space ? w_gnt : '0;
  assign w_push    = |(valid_in & ready_in);
  assign w_pop     = valid_out && ready_out;
  assign w_rr_next = (w_gnt_idx == SELW'(NUM_REQS - 1)) ? '0 : w_gnt_idx + SELW'(1);

  // Lane-OR of fflags is resolved here so the output stage is a plain register.
  always_comb begin
    int gi;
    gi           = int'(w_gnt_idx);
    w_new        = '0;
    w_new.sel    = w_gnt_idx;
    w_new.tag    = tag_in[gi*TAGW +: TAGW];
    w_new.res    = result_in[gi*LANES*32 +: LANES*32];
    w_new.has_ff = has_fflags_in[gi];
    if (has_fflags_in[gi]) begin
      for (int l = 0; l < LANES; l++) begin
        w_new.ff = w_new.ff | fflags_in[(gi*LANES + l)*5 +: 5];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= 2'd0;
      r_rr_ptr <= '0;
      r_head   <= '0;
      r_tail   <= '0;
    end else begin
      if (w_push) r_rr_ptr <= w_rr_next;
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= w_new;
          else                 r_tail <= w_new;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        // Simultaneous push/pop only happens with one entry, so the new one becomes head.
        2'b11: r_head <= w_new;
        default: ;
      endcase
    end
  end

  assign valid_out      = (r_count != 2'd0);
  assign tag_out        = r_head.tag;
  assign result_out     = r_head.res;
  assign has_fflags_out = r_head.has_ff;
  assign fflags_out     = r_head.ff;
  assign sel_out        = r_head.sel;

endmodule
